// File: rtl/serial_byte_loader_if.sv
// Serial-in / word-out bundle between a bit source and serial_byte_loader.
// master drives the serial side, slave (the loader) drives the word side.
interface serial_byte_loader_if #(
    parameter int WIDTH = 8
);
    logic             sdi;
    logic             sdi_valid;
    logic             abort;
    logic [WIDTH-1:0] d_out;
    logic             latch_en;
    logic             busy;
    logic [3:0]       bit_cnt;
    logic             par_err;

    modport master (
        output sdi, sdi_valid, abort,
        input  d_out, latch_en, busy, bit_cnt, par_err
    );

    modport slave (
        input  sdi, sdi_valid, abort,
        output d_out, latch_en, busy, bit_cnt, par_err
    );
endinterface

// File: rtl/serial_byte_loader.sv
// Purpose: deserialises WIDTH bits into d_out with a one-cycle latch_en strobe (optional even parity: SBL_PARITY_EN).
// Latency: d_out/latch_en update on the same edge that samples the final bit; latch_en drops one edge later.
// Backpressure: none; every sdi_valid cycle is consumed and the downstream latch cannot stall the stream.
module serial_byte_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_byte_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_in;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             latch_q, latch_d;
`ifdef SBL_PARITY_EN
    logic             perr_q, perr_d;
`endif

    always_comb begin
        if (MSB_FIRST) begin
            shift_in = {shift_q[WIDTH-2:0], bus.sdi};
        end else begin
            shift_in = {bus.sdi, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        latch_d = 1'b0;
`ifdef SBL_PARITY_EN
        perr_d  = 1'b0;
`endif
        // abort outranks a coincident valid bit: the bit is dropped with the frame
        if (bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (bus.sdi_valid) begin
            case (state_q)
                S_IDLE, S_SHIFT: begin
                    shift_d = shift_in;
                    if (cnt_q == LAST_CNT) begin
`ifdef SBL_PARITY_EN
                        state_d = S_PARITY;
                        cnt_d   = cnt_q + 4'd1;
`else
                        dout_d  = shift_in;
                        latch_d = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = S_SHIFT;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
`ifdef SBL_PARITY_EN
                S_PARITY: begin
                    // even parity: the parity bit equals the XOR of the data bits
                    if ((^shift_q) == bus.sdi) begin
                        dout_d  = shift_q;
                        latch_d = 1'b1;
                    end else begin
                        perr_d  = 1'b1;
                    end
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            latch_q <= 1'b0;
`ifdef SBL_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            latch_q <= latch_d;
`ifdef SBL_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.d_out    = dout_q;
    assign bus.latch_en = latch_q;
    assign bus.busy     = (cnt_q != 4'd0);
    assign bus.bit_cnt  = cnt_q;
`ifdef SBL_PARITY_EN
    assign bus.par_err  = perr_q;
`else
    assign bus.par_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader: an LSB-first and an MSB-first instance share one serial stream
// and are checked every cycle against a frame-queue model plus literal expectations.
module tb_serial_byte_loader;

    localparam int W = 8;
`ifdef SBL_PARITY_EN
    localparam int FLEN = W + 1;
    localparam bit PAR  = 1'b1;
`else
    localparam int FLEN = W;
    localparam bit PAR  = 1'b0;
`endif

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic sdi       = 1'b0;
    logic sdi_valid = 1'b0;
    logic abort     = 1'b0;

    always #5 clk = ~clk;

    serial_byte_loader_if #(.WIDTH(W)) bus_l ();
    serial_byte_loader_if #(.WIDTH(W)) bus_m ();

    assign bus_l.sdi       = sdi;
    assign bus_l.sdi_valid = sdi_valid;
    assign bus_l.abort     = abort;
    assign bus_m.sdi       = sdi;
    assign bus_m.sdi_valid = sdi_valid;
    assign bus_m.abort     = abort;

    serial_byte_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bus_l));
    serial_byte_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(bus_m));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: collect the bits of the current frame, build the word once the frame is full.
    bit             frame[$];
    logic [W-1:0]   m_dl, m_dm;
    bit             m_latch, m_perr;
    int             m_cnt;
    bit             model_on = 1'b0;

    always @(posedge clk) begin : model
        int           ones;
        logic [W-1:0] wl, wm;
        m_latch = 1'b0;
        m_perr  = 1'b0;
        if (rst) begin
            frame.delete();
            m_dl     = '0;
            m_dm     = '0;
            model_on = 1'b1;
        end else if (abort) begin
            frame.delete();
        end else if (sdi_valid) begin
            frame.push_back(sdi);
            if (frame.size() == FLEN) begin
                ones = 0;
                for (int i = 0; i < W; i++) begin
                    wl[i]     = frame[i];
                    wm[W-1-i] = frame[i];
                    ones      = ones + int'(frame[i]);
                end
                if (PAR) begin
                    if ((ones % 2) == int'(frame[W])) begin
                        m_dl = wl; m_dm = wm; m_latch = 1'b1;
                    end else begin
                        m_perr = 1'b1;
                    end
                end else begin
                    m_dl = wl; m_dm = wm; m_latch = 1'b1;
                end
                frame.delete();
            end
        end
        m_cnt = frame.size();
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("d_out_lsb",    32'(bus_l.d_out),    32'(m_dl));
            chk("d_out_msb",    32'(bus_m.d_out),    32'(m_dm));
            chk("latch_en_lsb", 32'(bus_l.latch_en), 32'(m_latch));
            chk("latch_en_msb", 32'(bus_m.latch_en), 32'(m_latch));
            chk("bit_cnt_lsb",  32'(bus_l.bit_cnt),  32'(m_cnt));
            chk("bit_cnt_msb",  32'(bus_m.bit_cnt),  32'(m_cnt));
            chk("busy_lsb",     32'(bus_l.busy),     32'(m_cnt != 0));
            chk("busy_msb",     32'(bus_m.busy),     32'(m_cnt != 0));
            chk("par_err_lsb",  32'(bus_l.par_err),  32'(m_perr));
            chk("par_err_msb",  32'(bus_m.par_err),  32'(m_perr));
        end
    end

    int cyc = 0;
    int strobes = 0;
    int last_strobe_cyc = 0;
    int strobe_gap = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (model_on && bus_l.latch_en === 1'b1) begin
            strobes++;
            strobe_gap      = cyc - last_strobe_cyc;
            last_strobe_cyc = cyc;
        end
    end

    task automatic send_bit(input logic b);
        sdi       = b;
        sdi_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sdi_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) send_bit(w[i]);
        if (PAR) send_bit(^w);
    endtask

    initial begin : stim
        logic [W-1:0] v;
        int s0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_d_out",   32'(bus_l.d_out),    32'h0);
        chk("reset_busy",    32'(bus_l.busy),     32'h0);
        chk("reset_bit_cnt", 32'(bus_l.bit_cnt),  32'h0);
        chk("reset_latch",   32'(bus_l.latch_en), 32'h0);

        // Bits 1,0,1,0,0,1,0,1 on consecutive cycles
        s0 = strobes;
        v  = 8'hA5;
        for (int i = 0; i < W; i++) begin
            send_bit(v[i]);
            if (i == 2) chk("t1_bit_cnt_3", 32'(bus_l.bit_cnt), 32'd3);
        end
        if (PAR) send_bit(^v);
        chk("t1_latch_en", 32'(bus_l.latch_en), 32'h1);
        chk("t1_d_lsb",    32'(bus_l.d_out),    32'hA5);
        chk("t1_d_msb",    32'(bus_m.d_out),    32'hA5);
        chk("t1_cnt_wrap", 32'(bus_l.bit_cnt),  32'h0);
        idle(1);
        chk("t1_latch_fall", 32'(bus_l.latch_en), 32'h0);
        chk("t1_strobes",    32'(strobes - s0),   32'd1);

        // Same sequence with a 3-cycle gap between bits 4 and 5
        s0 = strobes;
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        idle(3);
        chk("t2_gap_cnt",  32'(bus_l.bit_cnt), 32'd4);
        chk("t2_gap_busy", 32'(bus_m.busy),    32'h1);
        for (int i = 4; i < W; i++) send_bit(v[i]);
        if (PAR) send_bit(^v);
        chk("t2_d_msb", 32'(bus_m.d_out), 32'hA5);
        idle(1);
        chk("t2_strobes", 32'(strobes - s0), 32'd1);

        // Back-to-back frames, no dead cycle
        s0 = strobes;
        send_word(8'h3C);
        chk("t3_first_d",     32'(bus_l.d_out),    32'h3C);
        chk("t3_first_latch", 32'(bus_l.latch_en), 32'h1);
        send_word(8'hC3);
        chk("t3_second_d", 32'(bus_l.d_out), 32'hC3);
        idle(1);
        chk("t3_strobes",    32'(strobes - s0), 32'd2);
        chk("t3_strobe_gap", 32'(strobe_gap),   32'(FLEN));

        // Abort in IDLE, then abort mid-frame together with a valid bit
        s0 = strobes;
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        chk("t4_idle_abort_d", 32'(bus_l.d_out), 32'hC3);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        abort = 1'b1;
        send_bit(1'b1);
        abort = 1'b0;
        chk("t4_abort_cnt",   32'(bus_l.bit_cnt),  32'h0);
        chk("t4_abort_latch", 32'(bus_l.latch_en), 32'h0);
        send_word(8'h12);
        chk("t4_d_lsb", 32'(bus_l.d_out), 32'h12);
        chk("t4_d_msb", 32'(bus_m.d_out), 32'h48);
        idle(1);
        chk("t4_strobes", 32'(strobes - s0), 32'd1);

        // Reset after 5 bits
        s0 = strobes;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        sdi_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_d_lsb", 32'(bus_l.d_out), 32'h0);
        chk("t5_d_msb", 32'(bus_m.d_out), 32'h0);
        chk("t5_busy",  32'(bus_l.busy),  32'h0);
        idle(2);
        chk("t5_strobes", 32'(strobes - s0), 32'd0);

`ifdef SBL_PARITY_EN
        // Good parity, then bad parity on the same data
        s0 = strobes;
        v  = 8'h07;
        for (int i = 0; i < W; i++) send_bit(v[i]);
        send_bit(1'b1);
        chk("t6_good_latch", 32'(bus_l.latch_en), 32'h1);
        chk("t6_good_d",     32'(bus_l.d_out),    32'h07);
        idle(1);
        for (int i = 0; i < W; i++) send_bit(v[i]);
        send_bit(1'b0);
        chk("t6_bad_par_err", 32'(bus_l.par_err),  32'h1);
        chk("t6_bad_latch",   32'(bus_l.latch_en), 32'h0);
        chk("t6_bad_d_lsb",   32'(bus_l.d_out),    32'h07);
        chk("t6_bad_d_msb",   32'(bus_m.d_out),    32'hE0);
        idle(1);
        chk("t6_par_err_fall", 32'(bus_l.par_err),  32'h0);
        chk("t6_strobes",      32'(strobes - s0),   32'd1);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
